mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port 1024x32 word memory.
- The instruction-fetch port (im, read-only) and the data port (dm, read/write) share the memory through one valid/ready request channel each.
- Grants are round-robin, with one transaction in flight at a time.
- The block drives the memory's addr/wr_en/rd_en/data inputs, captures its registered read data, and returns responses to the granted requester.

Parameters:
- addr_p, 10, word-address width; must match the memory's addr_p.
- data_width_p, 32, data word width; must match the memory's data_width_p.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset, active-low, asynchronous.
- im_req_valid_i  in  1  fetch request valid.
- im_req_ready_o  out  1  fetch request accepted this cycle.
- im_addr_i  in  addr_p  fetch word address.
- im_rsp_valid_o  out  1  fetch data valid, one-cycle pulse.
- im_rdata_o  out  data_width_p  fetch read data.
- dm_req_valid_i  in  1  data request valid.
- dm_req_ready_o  out  1  data request accepted this cycle.
- dm_addr_i  in  addr_p  data word address.
- dm_we_i  in  1  1=write, 0=read.
- dm_wdata_i  in  data_width_p  write data.
- dm_rsp_valid_o  out  1  read data valid or write ack, one-cycle pulse.
- dm_rdata_o  out  data_width_p  data read data; 0 on write ack.
- mem_addr_o  out  addr_p  to memory addr_i.
- mem_wr_en_o  out  1  to memory wr_en_i.
- mem_rd_en_o  out  1  to memory rd_en_i.
- mem_wdata_o  out  data_width_p  to memory data_i.
- mem_rdata_i  in  data_width_p  from memory data_o, registered, valid one cycle after rd_en.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rstn_i.
- Reset values:
  - state=IDLE, last_gnt=DM, so IM wins the first tie.
  - All ready, rsp_valid, mem_wr_en_o and mem_rd_en_o are 0.
  - mem_addr_o, mem_wdata_o, im_rdata_o and dm_rdata_o are 0.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: ready is asserted combinationally to the arbitration winner only, when any valid is high. On handshake, latch port id, addr, we and wdata, then go to ISSUE. With no valid, stay in IDLE.
  - ISSUE: drive mem_addr_o from the latch. Assert mem_rd_en_o (read) or mem_wr_en_o plus mem_wdata_o (write) for exactly one cycle. Go to RESP.
  - RESP:
    - Pulse the owner's rsp_valid.
    - For a read, rdata_o = mem_rdata_i sampled this cycle. For a write, rdata_o = 0.
    - Both ready outputs follow the IDLE rule in this same cycle, so back-to-back accepts are allowed.
    - With a handshake, go to ISSUE; otherwise go to IDLE.
- Latency: accept at cycle N, memory strobe at N+1, rsp_valid at N+2. Sustained throughput is one transaction per 2 cycles.
- Arbitration:
  - Only one valid: that port wins.
  - Both valid: the port not equal to last_gnt wins. last_gnt updates on each handshake.
  - A requester holding valid is guaranteed a grant within 2 handshakes.
- Handshake rules:
  - A request transfers when valid && ready.
  - The requester holds addr/we/wdata stable while valid && !ready. The arbiter does not require this after the handshake, because inputs are latched.
  - Responses have no backpressure; the requester must sink the rsp pulse.
  - im has no write path. The memory write enable never asserts for an im transaction.
- Non-owner outputs: the non-owning rsp_valid stays 0. The non-owning rdata_o holds its last value.
- Memory controls are 0 in every state except ISSUE.
- Reset mid-operation: the async clear aborts any in-flight transaction. No response is issued for it. A pending write that had not reached ISSUE is not performed.
- Write then read to the same address, back-to-back: returns the new data. This follows from the one-outstanding ordering: the write completes at ISSUE before the read's ISSUE.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;
  - typedef enum logic {PORT_IM, PORT_DM} port_e;
  - a packed request struct {addr, we, wdata, port}.
- One natural sub-module, rr_arb2: the combinational 2-way round-robin grant plus the last_gnt register, reused for future masters.

Test Plan:
- After reset, im reads addr 0x004 alone: im_req_ready_o=1 at N, mem_rd_en_o=1 with mem_addr_o=0x004 at N+1, im_rsp_valid_o=1 at N+2 with im_rdata_o=memory content.
- dm writes 0xDEADBEEF to 0x010, then reads 0x010: write strobe with mem_wdata_o=0xDEADBEEF. Write ack has dm_rdata_o=0. Read response is 0xDEADBEEF 2 cycles after its accept.
- im and dm both held valid for 6 cycles after reset: grants alternate IM, DM, IM. Neither port is ever granted twice consecutively while the other waits.
- Continuous dm reads to 0x001..0x004: accepts at N, N+2, N+4, N+6. rsp_valid at N+2, N+4, N+6, N+8. mem_rd_en_o is never high in two consecutive cycles.
- rstn_i dropped asynchronously during ISSUE of a dm write to 0x020: all outputs clear immediately. No dm_rsp_valid_o. After release the FSM is in IDLE and the first tie goes to IM.
- im valid with dm idle, then dm asserts during im's RESP cycle: dm_req_ready_o=1 in that RESP cycle, and its ISSUE follows the next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Contents:
//   addr_w_c, data_w_c : word-address and data widths of the 1024x32 memory
//   arb_state_e        : sequencer states (IDLE, ISSUE, RESP)
//   port_e             : requester identity (PORT_IM fetch, PORT_DM data)
//   mem_req_t          : one latched request {addr, we, wdata, port}
package mem_arb_pkg;

  localparam int addr_w_c = 10;
  localparam int data_w_c = 32;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;

  typedef enum logic {PORT_IM, PORT_DM} port_e;

  typedef struct packed {
    logic [addr_w_c-1:0] addr;
    logic                we;
    logic [data_w_c-1:0] wdata;
    port_e               port;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester channel of the memory arbiter: a valid/ready request
// (addr, we, wdata) and an unthrottled one-cycle response (rsp_valid, rdata).
// Modports:
//   master : the requester (drives the request, sinks the response)
//   slave  : the arbiter   (accepts the request, drives the response)
// The fetch port uses the same channel; its we/wdata are ignored by the arbiter.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int addr_p       = addr_w_c,
  parameter int data_width_p = data_w_c
);

  logic                    req_valid;
  logic                    req_ready;
  logic [addr_p-1:0]       addr;
  logic                    we;
  logic [data_width_p-1:0] wdata;
  logic                    rsp_valid;
  logic [data_width_p-1:0] rdata;

  modport master (
    output req_valid, addr, we, wdata,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, addr, we, wdata,
    output req_ready, rsp_valid, rdata
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with its last-grant register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit 0 = PORT_IM, bit 1 = PORT_DM
//   accept     : the current grant was taken this cycle; remember its owner
//   gnt[1:0]   : one-hot combinational grant (all zero when nothing requests)
// After reset the last grant is PORT_DM, so PORT_IM wins the first tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  port_e last_gnt;

  always_comb begin
    // NOTE: every combinational output gets a default before the case so
    // no path leaves it unassigned, which would otherwise infer a latch.
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_gnt == PORT_DM) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    if (!rst_n) begin
      last_gnt <= PORT_DM;
    end else if (accept) begin
      last_gnt <= gnt[1] ? PORT_DM : PORT_IM;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port 1024x32 memory between the fetch
// port (im, read-only) and the data port (dm, read/write). One transaction
// is in flight at a time: accept (IDLE or RESP) -> strobe memory (ISSUE)
// -> respond with the memory's registered read data (RESP).
// Ports:
//   clk_i, rstn_i      : clock, asynchronous active-low reset
//   im, dm             : requester channels (mem_arbiter_if.slave)
//   mem_addr_o         : memory word address, non-zero only in ISSUE
//   mem_wr_en_o        : memory write strobe, one cycle
//   mem_rd_en_o        : memory read strobe, one cycle
//   mem_wdata_o        : memory write data, non-zero only for a write strobe
//   mem_rdata_i        : memory read data, valid the cycle after mem_rd_en_o
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int addr_p       = addr_w_c,
  parameter int data_width_p = data_w_c
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  mem_arbiter_if.slave            im,
  mem_arbiter_if.slave            dm,
  output logic [addr_p-1:0]       mem_addr_o,
  output logic                    mem_wr_en_o,
  output logic                    mem_rd_en_o,
  output logic [data_width_p-1:0] mem_wdata_o,
  input  logic [data_width_p-1:0] mem_rdata_i
);

  arb_state_e              state_q, state_d;
  mem_req_t                req_q, req_d;
  logic [1:0]              gnt;
  logic                    open;
  logic                    accept;
  logic                    im_rsp, dm_rsp;
  logic [data_width_p-1:0] resp_data;
  logic [data_width_p-1:0] im_rdata_q, dm_rdata_q;

  rr_arb2 u_rr_arb2 (
    .clk    (clk_i),
    .rst_n  (rstn_i),
    .req    ({dm.req_valid, im.req_valid}),
    .accept (accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d     = state_q;
    mem_addr_o  = '0;
    mem_wr_en_o = 1'b0;
    mem_rd_en_o = 1'b0;
    mem_wdata_o = '0;
    im_rsp      = 1'b0;
    dm_rsp      = 1'b0;
    resp_data   = '0;

    // The channel is open in IDLE and in RESP, which lets a new request be
    // accepted in the same cycle the previous one responds.
    open         = (state_q == IDLE) || (state_q == RESP);
    im.req_ready = open & gnt[0];
    dm.req_ready = open & gnt[1];
    accept       = open & (|gnt);

    // Fetch requests never carry a write, whatever im drives on we/wdata.
    if (gnt[1]) begin
      req_d = '{addr: dm.addr, we: dm.we, wdata: dm.wdata, port: PORT_DM};
    end else begin
      req_d = '{addr: im.addr, we: 1'b0, wdata: '0, port: PORT_IM};
    end

    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        mem_addr_o  = req_q.addr;
        mem_rd_en_o = !req_q.we;
        mem_wr_en_o = req_q.we;
        mem_wdata_o = req_q.we ? req_q.wdata : '0;
        state_d     = RESP;
      end
      RESP: begin
        im_rsp    = (req_q.port == PORT_IM);
        dm_rsp    = (req_q.port == PORT_DM);
        resp_data = req_q.we ? '0 : mem_rdata_i;
        state_d   = accept ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase

    // rdata shows the live response during RESP and the last response
    // delivered to that port otherwise.
    im.rsp_valid = im_rsp;
    dm.rsp_valid = dm_rsp;
    im.rdata     = im_rsp ? resp_data : im_rdata_q;
    dm.rdata     = dm_rsp ? resp_data : dm_rdata_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    // NOTE: the request latch and the held-rdata registers are reset too,
    // because their contents are visible on outputs straight out of reset.
    if (!rstn_i) begin
      state_q    <= IDLE;
      req_q      <= '0;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) req_q      <= req_d;
      if (im_rsp) im_rdata_q <= resp_data;
      if (dm_rsp) dm_rdata_q <= resp_data;
    end
  end

endmodule
